// File: rtl/arrow_seq_ctrl_pkg.sv
// Shared game definitions: sequencer state encoding, arrow direction codes
// and the LFSR feedback mask used by every random-event block.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_PLAY = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } arrow_state_t;

  localparam logic [1:0] DIR_DOWN = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_H0   = 2'b10;
  localparam logic [1:0] DIR_H1   = 2'b11;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One right-shifting Galois step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/arrow_seq_ctrl_if.sv
// Bundle between the input decoder / HUD side and the arrow sequencer.
// Handshake: start_in and dir_valid_in are one-cycle strobes with no ready; the
// sequencer samples them on every edge and acts only in the states that accept them.
interface arrow_seq_ctrl_if #(
  parameter int NUM_ARROWS = 8
);
  logic                      start_in;
  logic                      dir_valid_in;
  logic [1:0]                dir_in;
  logic [2*NUM_ARROWS-1:0]   rotate_out;
  logic [NUM_ARROWS-1:0]     inversed_out;
  logic [NUM_ARROWS-1:0]     next_out;
  logic [NUM_ARROWS-1:0]     visible_out;
  logic [15:0]               time_left_out;
  logic [7:0]                score_out;
  logic                      round_done_out;
  logic                      fail_out;
  logic [2:0]                state_out;

  modport master (
    output start_in, dir_valid_in, dir_in,
    input  rotate_out, inversed_out, next_out, visible_out,
           time_left_out, score_out, round_done_out, fail_out, state_out
  );

  modport slave (
    input  start_in, dir_valid_in, dir_in,
    output rotate_out, inversed_out, next_out, visible_out,
           time_left_out, score_out, round_done_out, fail_out, state_out
  );
endinterface

// File: rtl/arrow_seq_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR; shifts every cycle, reloads the seed on reset.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [15:0] state_out
);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_out <= SEED;
    else        state_out <= lfsr_step(state_out);
  end

endmodule

// File: rtl/arrow_seq_ctrl.sv
// Round sequencer: fills a row of random arrows, checks player presses against
// the target slot under a time limit, and reports score / success / failure.
module arrow_seq_ctrl
  import game_pkg::*;
#(
  parameter int          NUM_ARROWS = 8,
  parameter logic [15:0] TIME_LIMIT = 16'd600,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  arrow_seq_ctrl_if.slave    bus
);

  localparam int PW = (NUM_ARROWS > 1) ? $clog2(NUM_ARROWS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_ARROWS - 1);

  arrow_state_t  state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [15:0]   time_q, time_d;
  logic [7:0]    score_q, score_d;
  logic          done_q, done_d;
  logic          fill_we;
  logic [1:0]    rot_q [NUM_ARROWS];
  logic          inv_q [NUM_ARROWS];
  logic [1:0]    req_dir;
  logic [15:0]   lfsr;
  logic          lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .state_out (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:4];

  // An inverted arrow wants the other member of its direction pair.
  assign req_dir = rot_q[ptr_q] ^ {1'b0, inv_q[ptr_q]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    time_d  = time_q;
    score_d = score_q;
    done_d  = 1'b0;
    fill_we = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start_in) begin
          state_d = ST_FILL;
          ptr_d   = '0;
          if (state_q == ST_FAIL) score_d = 8'd0;
        end
      end
      ST_FILL: begin
        fill_we = 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_PLAY;
          ptr_d   = '0;
          time_d  = TIME_LIMIT;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_PLAY: begin
        // A press is evaluated even in the cycle the timer has run out.
        if (bus.dir_valid_in) begin
          if (bus.dir_in == req_dir) begin
            if (ptr_q == LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end else begin
            state_d = ST_FAIL;
          end
        end else if (time_q == 16'd0) begin
          state_d = ST_FAIL;
        end else begin
          time_d = time_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      time_q  <= 16'd0;
      score_q <= 8'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_ARROWS; i++) begin
        rot_q[i] <= 2'b00;
        inv_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      time_q  <= time_d;
      score_q <= score_d;
      done_q  <= done_d;
      if (fill_we) begin
        rot_q[ptr_q] <= lfsr[1:0];
        inv_q[ptr_q] <= (lfsr[3:2] == 2'b11);
      end
    end
  end

  logic [2*NUM_ARROWS-1:0] rotate_v;
  logic [NUM_ARROWS-1:0]   inversed_v, next_v, visible_v;

  always_comb begin
    rotate_v   = '0;
    inversed_v = '0;
    next_v     = '0;
    visible_v  = '0;
    for (int i = 0; i < NUM_ARROWS; i++) begin
      rotate_v[2*i +: 2] = rot_q[i];
      inversed_v[i]      = inv_q[i];
      next_v[i]          = (state_q == ST_PLAY) && (ptr_q == PW'(i));
      if (state_q == ST_PLAY || state_q == ST_FAIL) visible_v[i] = (PW'(i) >= ptr_q);
      else if (state_q == ST_DONE)                  visible_v[i] = 1'b1;
    end
  end

  assign bus.rotate_out     = rotate_v;
  assign bus.inversed_out   = inversed_v;
  assign bus.next_out       = next_v;
  assign bus.visible_out    = visible_v;
  assign bus.time_left_out  = time_q;
  assign bus.score_out      = score_q;
  assign bus.round_done_out = done_q;
  assign bus.fail_out       = (state_q == ST_FAIL);
  assign bus.state_out      = state_q;

endmodule

// File: tb/tb_arrow_seq_ctrl.sv
// Directed bench for arrow_seq_ctrl with NUM_ARROWS=4, TIME_LIMIT=20; slot
// contents are predicted by an independent LFSR model clocked alongside the DUT.
module tb_arrow_seq_ctrl;
  import game_pkg::*;

  localparam int          N  = 4;
  localparam logic [15:0] TL = 16'd20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arrow_seq_ctrl_if #(.NUM_ARROWS(N)) bus ();

  arrow_seq_ctrl #(.NUM_ARROWS(N), .TIME_LIMIT(TL), .LFSR_SEED(16'hACE1)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0]  lfsr_m;
  logic [1:0]   exp_rot [N];
  logic         exp_inv [N];
  logic [N-1:0] exp_q[$];

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 16'hB400;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= model_step(lfsr_m);
  end

  function automatic logic [1:0] req(input int k);
    return exp_rot[k] ^ {1'b0, exp_inv[k]};
  endfunction

  // Pulse start at a negedge and record the slot values the fill will latch.
  task automatic start_round();
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_rot[k] = lfsr_m[1:0];
      exp_inv[k] = (lfsr_m[3:2] == 2'b11);
      @(negedge clk);
    end
  endtask

  task automatic press(input logic [1:0] d);
    bus.dir_valid_in = 1'b1;
    bus.dir_in       = d;
    @(negedge clk);
    bus.dir_valid_in = 1'b0;
  endtask

  // Start rounds until one holds an inverted slot; leave the pointer on it.
  task automatic seek_inverted(output int k);
    k = -1;
    for (int a = 0; a < 40 && k < 0; a++) begin
      start_round();
      for (int j = N - 1; j >= 0; j--) if (exp_inv[j]) k = j;
      if (k >= 0) begin
        for (int j = 0; j < k; j++) press(req(j));
      end else begin
        for (int j = 0; j < N; j++) press(req(j));
      end
    end
  endtask

  task automatic test_reset();
    logic [2*N-1:0] er;
    logic [N-1:0]   ei;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_out); end
    checks++; if ({bus.rotate_out, bus.inversed_out, bus.next_out, bus.visible_out} !== '0) begin
      errors++; $display("FAIL reset_slots: got %h expected 0", {bus.rotate_out, bus.inversed_out, bus.next_out, bus.visible_out}); end
    checks++; if ({bus.time_left_out, bus.score_out, bus.round_done_out, bus.fail_out} !== '0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", {bus.time_left_out, bus.score_out, bus.round_done_out, bus.fail_out}); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) press(DIR_UP);
    checks++; if (bus.state_out !== 3'd0 || bus.next_out !== '0) begin
      errors++; $display("FAIL idle_ignores_dir: got state %0d next %b expected 0/0000", bus.state_out, bus.next_out); end
    start_round();
    for (int k = 0; k < N; k++) begin
      er[2*k +: 2] = exp_rot[k];
      ei[k]        = exp_inv[k];
    end
    checks++; if (bus.rotate_out !== er) begin errors++; $display("FAIL fill_rotate: got %b expected %b", bus.rotate_out, er); end
    checks++; if (bus.inversed_out !== ei) begin errors++; $display("FAIL fill_inversed: got %b expected %b", bus.inversed_out, ei); end
    checks++; if (bus.state_out !== 3'd2 || bus.time_left_out !== TL) begin
      errors++; $display("FAIL play_entry: got state %0d time %0d expected 2/%0d", bus.state_out, bus.time_left_out, TL); end
  endtask

  task automatic test_correct_sequence();
    logic [N-1:0] e;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    for (int k = 0; k < N; k++) begin
      e = exp_q.pop_front();
      checks++; if (bus.next_out !== e) begin errors++; $display("FAIL walk_next%0d: got %b expected %b", k, bus.next_out, e); end
      e = 4'b1111 << k;
      checks++; if (bus.visible_out !== e) begin errors++; $display("FAIL walk_visible%0d: got %b expected %b", k, bus.visible_out, e); end
      press(req(k));
    end
    checks++; if (bus.state_out !== 3'd3 || bus.round_done_out !== 1'b1 || bus.score_out !== 8'd1) begin
      errors++; $display("FAIL round_done: got state %0d done %b score %0d expected 3/1/1", bus.state_out, bus.round_done_out, bus.score_out); end
    checks++; if (bus.next_out !== 4'b0000 || bus.visible_out !== 4'b1111) begin
      errors++; $display("FAIL done_outputs: got next %b vis %b expected 0000/1111", bus.next_out, bus.visible_out); end
    @(negedge clk);
    checks++; if (bus.round_done_out !== 1'b0 || bus.state_out !== 3'd3) begin
      errors++; $display("FAIL done_pulse: got done %b state %0d expected 0/3", bus.round_done_out, bus.state_out); end
  endtask

  task automatic test_wrong_press();
    start_round();
    press(req(0));
    press(req(1));
    press(req(2) ^ 2'b10);
    checks++; if (bus.state_out !== 3'd4 || bus.fail_out !== 1'b1) begin
      errors++; $display("FAIL wrong_fail: got state %0d fail %b expected 4/1", bus.state_out, bus.fail_out); end
    checks++; if (bus.next_out !== 4'b0000 || bus.visible_out !== 4'b1100 || bus.score_out !== 8'd1) begin
      errors++; $display("FAIL wrong_outputs: got next %b vis %b score %0d expected 0000/1100/1", bus.next_out, bus.visible_out, bus.score_out); end
    start_round();
    checks++; if (bus.score_out !== 8'd0 || bus.fail_out !== 1'b0 || bus.state_out !== 3'd2) begin
      errors++; $display("FAIL restart_clear: got score %0d fail %b state %0d expected 0/0/2", bus.score_out, bus.fail_out, bus.state_out); end
  endtask

  task automatic test_inversed();
    int k;
    logic [N-1:0] e;
    seek_inverted(k);
    checks++;
    if (k < 0) begin
      errors++; $display("FAIL inv_search: got none expected inverted slot");
    end else begin
      press(exp_rot[k]);
      if (bus.state_out !== 3'd4) begin errors++; $display("FAIL inv_unflipped: got state %0d expected 4", bus.state_out); end
    end
    seek_inverted(k);
    checks++;
    if (k < 0) begin
      errors++; $display("FAIL inv_search2: got none expected inverted slot");
    end else begin
      press(exp_rot[k] ^ 2'b01);
      if (k == N - 1) begin
        if (bus.state_out !== 3'd3) begin errors++; $display("FAIL inv_flipped_last: got state %0d expected 3", bus.state_out); end
      end else begin
        e = 4'b0001 << (k + 1);
        if (bus.next_out !== e) begin errors++; $display("FAIL inv_flipped: got next %b expected %b", bus.next_out, e); end
        for (int j = k + 1; j < N; j++) press(req(j));
      end
    end
  endtask

  task automatic test_timeout();
    start_round();
    for (int c = 0; c <= 20; c++) begin
      checks++; if (bus.state_out !== 3'd2 || bus.time_left_out !== 16'(20 - c)) begin
        errors++; $display("FAIL countdown%0d: got state %0d time %0d expected 2/%0d", c, bus.state_out, bus.time_left_out, 20 - c); end
      @(negedge clk);
    end
    checks++; if (bus.state_out !== 3'd4 || bus.fail_out !== 1'b1) begin
      errors++; $display("FAIL timeout_fail: got state %0d fail %b expected 4/1", bus.state_out, bus.fail_out); end
    start_round();
    for (int k = 0; k < N - 1; k++) press(req(k));
    repeat (20) @(negedge clk);
    checks++; if (bus.time_left_out !== 16'd0 || bus.state_out !== 3'd2) begin
      errors++; $display("FAIL last_cycle: got time %0d state %0d expected 0/2", bus.time_left_out, bus.state_out); end
    press(req(N - 1));
    checks++; if (bus.state_out !== 3'd3 || bus.round_done_out !== 1'b1) begin
      errors++; $display("FAIL late_press: got state %0d done %b expected 3/1", bus.state_out, bus.round_done_out); end
  endtask

  task automatic test_reset_mid();
    start_round();
    press(req(0));
    press(req(1));
    checks++; if (bus.next_out !== 4'b0100 || bus.score_out !== 8'd1) begin
      errors++; $display("FAIL mid_setup: got next %b score %0d expected 0100/1", bus.next_out, bus.score_out); end
    rst = 1'b1;
    bus.start_in = 1'b1;
    @(negedge clk);
    checks++; if ({bus.state_out, bus.rotate_out, bus.inversed_out, bus.next_out, bus.visible_out} !== '0) begin
      errors++; $display("FAIL mid_reset_slots: got %h expected 0", {bus.state_out, bus.rotate_out, bus.inversed_out, bus.next_out, bus.visible_out}); end
    checks++; if ({bus.time_left_out, bus.score_out, bus.round_done_out, bus.fail_out} !== '0) begin
      errors++; $display("FAIL mid_reset_status: got %h expected 0", {bus.time_left_out, bus.score_out, bus.round_done_out, bus.fail_out}); end
    bus.start_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_score_saturation();
    for (int r = 0; r < 256; r++) begin
      start_round();
      for (int k = 0; k < N; k++) press(req(k));
      if (r == 254) begin
        checks++; if (bus.score_out !== 8'd255) begin errors++; $display("FAIL score_255: got %0d expected 255", bus.score_out); end
      end
    end
    checks++; if (bus.score_out !== 8'd255 || bus.state_out !== 3'd3) begin
      errors++; $display("FAIL score_sat: got score %0d state %0d expected 255/3", bus.score_out, bus.state_out); end
  endtask

  initial begin
    bus.start_in     = 1'b0;
    bus.dir_valid_in = 1'b0;
    bus.dir_in       = DIR_DOWN;
    test_reset();
    test_correct_sequence();
    test_wrong_press();
    test_inversed();
    test_timeout();
    test_reset_mid();
    test_score_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arrow_seq_ctrl.md
# arrow_seq_ctrl

Round sequencer for the arrow-matching game. It generates a row of NUM_ARROWS pseudo-random arrows and drives the per-slot rotate/inversed/next controls of the arrow sprite instances. It checks the player's direction presses against the current target arrow and enforces a per-round time limit. It sits between the input debouncer/decoder and the sprite layer, and reports round success, failure and score to the top-level game FSM and HUD.

## Interface
Parameters:
- NUM_ARROWS, 8, number of arrow slots per round (2..16)
- TIME_LIMIT, 16'd600, round length in clock cycles
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- start_in  input  1  pulse: begin a new round (honoured in IDLE, DONE, FAIL only)
- dir_valid_in  input  1  one-cycle pulse: player pressed a direction
- dir_in  input  2  pressed direction, same encoding as sprite rotate (00/01 vertical pair, 10/11 horizontal pair)
- rotate_out  output  2*NUM_ARROWS  slot i rotation at [2i+1:2i]
- inversed_out  output  NUM_ARROWS  slot i is an inverted arrow
- next_out  output  NUM_ARROWS  one-hot current target slot; 0 outside PLAY
- visible_out  output  NUM_ARROWS  slot i should be drawn
- time_left_out  output  16  remaining cycles in round
- score_out  output  8  completed rounds, saturating at 255
- round_done_out  output  1  one-cycle pulse on successful round completion
- fail_out  output  1  high while in FAIL
- state_out  output  3  current state encoding

## Operation
- States: IDLE=0, FILL=1, PLAY=2, DONE=3, FAIL=4.
- Free-running 16-bit Galois LFSR, mask 16'hB400, shifts every cycle in all states. Reset value is LFSR_SEED.
- IDLE, DONE or FAIL with start_in=1 -> FILL. Fill index goes to 0. Leaving FAIL clears score to 0.
- FILL: one slot per cycle, index 0..NUM_ARROWS-1. Slot rotate = lfsr[1:0], inversed = (lfsr[3:2]==2'b11). After the last slot -> PLAY. The pointer goes to 0 and time_left goes to TIME_LIMIT.
- PLAY, required direction for the slot at the pointer = rotate ^ {1'b0, inversed}. An inverted arrow demands the opposite direction within its pair.
- PLAY, dir_valid_in with dir_in == required:
  - If pointer < NUM_ARROWS-1, increment the pointer.
  - If pointer == NUM_ARROWS-1, go to DONE, pulse round_done_out, and increment score (saturating).
- PLAY, dir_valid_in with a mismatching dir_in -> FAIL.
- PLAY, no dir_valid_in:
  - If time_left == 0 -> FAIL.
  - Otherwise decrement time_left.
- A press in the same cycle that time_left == 0 is still evaluated. The press takes priority over timeout.
- dir_valid_in is ignored outside PLAY. start_in is ignored in FILL and PLAY.
- Outputs by state:
  - next_out = one-hot(pointer) in PLAY, else 0.
  - visible_out[i] = (i >= pointer) in PLAY and FAIL, all 0 in IDLE and FILL, all 1 in DONE.
- Slot contents (rotate/inversed) hold their values until overwritten by the next FILL.
- DONE and FAIL hold until start_in.

## Timing
- All outputs are registered. Any input event at edge t is visible on outputs after edge t (cycle t+1).
- Reset values:
  - state IDLE, pointer 0, time_left_out 0, score_out 0.
  - rotate_out, inversed_out, next_out and visible_out all 0.
  - round_done_out 0, fail_out 0, LFSR = LFSR_SEED.
- Round start latency: start_in at cycle t gives FILL during t+1..t+NUM_ARROWS, and PLAY from t+NUM_ARROWS+1 with time_left = TIME_LIMIT.
- A round with no input lasts TIME_LIMIT+1 PLAY cycles, then FAIL.
- Reset asserted mid-round returns everything to reset values on the next edge. Reset overrides start_in.

## Structure
- Shared package game_pkg holds:
  - state enum arrow_state_t;
  - the direction encoding constants DIR_DOWN=2'b00, DIR_UP=2'b01, DIR_H0=2'b10, DIR_H1=2'b11;
  - the LFSR mask constant.
- One natural sub-module: lfsr16 (clk_in, rst_in, seed parameter, 16-bit state out). It is reused by other random-event blocks.
- Slot storage is plain register arrays inside arrow_seq_ctrl. The outputs are flattened for generate-loop hookup to the sprite instances.

## Test plan
- Reset (NUM_ARROWS=4, TIME_LIMIT=20):
  - all outputs are 0 and state_out=0;
  - dir_valid_in pulses are ignored;
  - after one start_in, the four rotate/inversed values match a bench LFSR model seeded 16'hACE1 at the same cycle offset.
- Correct sequence: press the required direction for each of the 4 slots.
  - The next_out one-hot walks 0001->0010->0100->1000.
  - visible_out shrinks 1111->1110->1100->1000.
  - round_done_out pulses once, score_out=1, state DONE.
- Wrong press on slot 2 -> FAIL the next cycle, with fail_out=1, next_out=0 and visible_out=1100. A following start_in clears score_out to 0.
- Inverted slot: a press of rotate (un-flipped) -> FAIL. A press of rotate^2'b01 -> the pointer advances.
- Timeout:
  - No presses -> time_left_out counts 20..0 and FAIL is entered exactly 21 cycles after PLAY entry.
  - A correct final press in the time_left==0 cycle instead -> DONE.
- Reset asserted mid-PLAY with pointer=2 -> all reset values on the next cycle. Score saturation: 256 forced completions leave score_out=255.
